// File: rtl/lock_pkg.sv
// Shared definitions for the keypad lock controller: FSM state encoding,
// special key codes and key-classification helpers.
package lock_pkg;

    // FSM state encoding; the numeric values are visible on the state output.
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ENTRY   = 3'd1,
        S_CHECK   = 3'd2,
        S_OPEN    = 3'd3,
        S_LOCKOUT = 3'd4,
        S_NEWPW   = 3'd5
    } lock_state_e;

    // Key codes: 0..9 are digits, 10 is '*', 11 is '#', 12..15 are invalid.
    localparam logic [3:0] KEY_STAR      = 4'd10;
    localparam logic [3:0] KEY_HASH      = 4'd11;
    localparam logic [3:0] DIGIT_MAX     = 4'd9;
    localparam logic [3:0] KEY_VALID_MAX = 4'd11;

    // True for the digit keys 0..9.
    function automatic logic is_digit(input logic [3:0] k);
        return (k <= DIGIT_MAX);
    endfunction

    // True for any key the controller reacts to (digits, '*', '#').
    function automatic logic is_valid_key(input logic [3:0] k);
        return (k <= KEY_VALID_MAX);
    endfunction

endpackage

// File: rtl/lock_ctrl_if.sv
// Keypad / status bundle between the keypad front end and lock_ctrl.
//
// Handshake: key_flag is a one-cycle strobe with no back-pressure. key_value
// is only meaningful in the cycle where key_flag is 1; it is ignored at all
// other times. The controller never stalls the keypad: every strobe is
// consumed (possibly as a no-op) in the cycle it is presented.
interface lock_ctrl_if;
    logic       key_flag;
    logic [3:0] key_value;
    logic       unlocked;
    logic       alarm;
    logic       err;
    logic       pw_chg;
    logic [3:0] digit_cnt;
    logic [2:0] state;

    // Keypad side: drives key strobes, observes lock status.
    modport master (
        output key_flag, key_value,
        input  unlocked, alarm, err, pw_chg, digit_cnt, state
    );

    // Controller side.
    modport slave (
        input  key_flag, key_value,
        output unlocked, alarm, err, pw_chg, digit_cnt, state
    );
endinterface

// File: rtl/lock_timer.sv
// Shared down-counter for the lock controller. A load takes priority and
// sets the count; otherwise the count decrements towards zero and holds.
// done_o is high in the single cycle the count sits at 1, so a load of N
// followed by no further loads gives exactly N cycles before the expiry edge.
module lock_timer #(
    parameter int TW = 29
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic [TW-1:0] load_value_i,
    output logic          done_o
);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    // Next count: load wins, otherwise count down and stop at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_value_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == TW'(1));

endmodule

// File: rtl/lock_ctrl.sv
// Keypad lock controller: collects a passcode, checks it, opens the lock for
// a fixed time, and locks the keypad out after repeated wrong entries.
// Optional feature macro: LOCK_PW_CHANGE_EN enables changing the passcode
// from the OPEN state ('#', new digits, '#'). Without it the passcode is the
// constant DEFAULT_PW and pw_chg is tied low.
module lock_ctrl
    import lock_pkg::*;
#(
    parameter int          PW_LEN          = 4,
    parameter logic [31:0] DEFAULT_PW      = 32'h0000_1234,
    parameter int          MAX_FAIL        = 3,
    parameter int          UNLOCK_CYCLES   = 50_000_000,
    parameter int          LOCKOUT_CYCLES  = 500_000_000,
    parameter int          ENTRY_TO_CYCLES = 250_000_000
) (
    input logic        clk,
    input logic        rst,
    lock_ctrl_if.slave bus
);

    localparam int BW    = 4 * PW_LEN;
    localparam int TMAX1 = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int TMAX  = (TMAX1 > ENTRY_TO_CYCLES) ? TMAX1 : ENTRY_TO_CYCLES;
    localparam int TW    = $clog2(TMAX + 1);
    localparam int FW    = (MAX_FAIL > 1) ? $clog2(MAX_FAIL + 1) : 1;

    localparam logic [TW-1:0] T_UNLOCK   = TW'(UNLOCK_CYCLES);
    localparam logic [TW-1:0] T_LOCKOUT  = TW'(LOCKOUT_CYCLES);
    localparam logic [TW-1:0] T_ENTRY_TO = TW'(ENTRY_TO_CYCLES);
    localparam logic [3:0]    PW_LEN_C   = 4'(PW_LEN);
    localparam logic [FW-1:0] MAX_FAIL_C = FW'(MAX_FAIL);

    localparam logic [2:0] ST_IDLE    = S_IDLE;
    localparam logic [2:0] ST_ENTRY   = S_ENTRY;
    localparam logic [2:0] ST_CHECK   = S_CHECK;
    localparam logic [2:0] ST_OPEN    = S_OPEN;
    localparam logic [2:0] ST_LOCKOUT = S_LOCKOUT;
`ifdef LOCK_PW_CHANGE_EN
    localparam logic [2:0] ST_NEWPW   = S_NEWPW;
`endif

    logic [2:0]    state_q, state_d;
    logic [BW-1:0] buf_q, buf_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [FW-1:0] fail_q, fail_d;
    logic [FW-1:0] fail_inc;
    logic          unlocked_q, alarm_q, err_q, err_d;
    logic [BW-1:0] pw_val;

    logic          timer_load;
    logic [TW-1:0] timer_val;
    logic          timer_done;

    logic          key_ok, key_dig, key_star, key_hash;
    logic          match;

`ifdef LOCK_PW_CHANGE_EN
    logic [BW-1:0] pw_q, pw_d;
    logic          pw_chg_q, pw_chg_d;
    assign pw_val = pw_q;
`else
    assign pw_val = DEFAULT_PW[BW-1:0];
`endif

    // Key classification; invalid codes 12..15 never count as a key at all.
    assign key_ok   = bus.key_flag && is_valid_key(bus.key_value);
    assign key_dig  = key_ok && is_digit(bus.key_value);
    assign key_star = key_ok && (bus.key_value == KEY_STAR);
    assign key_hash = key_ok && (bus.key_value == KEY_HASH);

    assign match    = (cnt_q == PW_LEN_C) && (buf_q == pw_val);
    assign fail_inc = fail_q + 1'b1;

    lock_timer #(.TW(TW)) u_timer (
        .clk          (clk),
        .rst          (rst),
        .load_i       (timer_load),
        .load_value_i (timer_val),
        .done_o       (timer_done)
    );

    // Main FSM: timer expiry is tested before keys so it wins a collision.
    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        cnt_d      = cnt_q;
        fail_d     = fail_q;
        err_d      = 1'b0;
        timer_load = 1'b0;
        timer_val  = '0;
`ifdef LOCK_PW_CHANGE_EN
        pw_d       = pw_q;
        pw_chg_d   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (key_dig) begin
                    buf_d      = BW'(bus.key_value);
                    cnt_d      = 4'd1;
                    state_d    = ST_ENTRY;
                    timer_load = 1'b1;
                    timer_val  = T_ENTRY_TO;
                end
            end
            ST_ENTRY: begin
                if (timer_done) begin
                    buf_d   = '0;
                    cnt_d   = 4'd0;
                    state_d = ST_IDLE;
                end else if (key_ok) begin
                    timer_load = 1'b1;
                    timer_val  = T_ENTRY_TO;
                    if (key_dig && (cnt_q < PW_LEN_C)) begin
                        buf_d = (buf_q << 4) | BW'(bus.key_value);
                        cnt_d = cnt_q + 1'b1;
                    end else if (key_star) begin
                        buf_d   = '0;
                        cnt_d   = 4'd0;
                        state_d = ST_IDLE;
                    end else if (key_hash) begin
                        state_d = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                buf_d = '0;
                cnt_d = 4'd0;
                if (match) begin
                    fail_d     = '0;
                    state_d    = ST_OPEN;
                    timer_load = 1'b1;
                    timer_val  = T_UNLOCK;
                end else begin
                    err_d  = 1'b1;
                    fail_d = fail_inc;
                    if (fail_inc == MAX_FAIL_C) begin
                        state_d    = ST_LOCKOUT;
                        timer_load = 1'b1;
                        timer_val  = T_LOCKOUT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_OPEN: begin
                if (timer_done || key_star) begin
                    state_d = ST_IDLE;
`ifdef LOCK_PW_CHANGE_EN
                end else if (key_hash) begin
                    buf_d      = '0;
                    cnt_d      = 4'd0;
                    state_d    = ST_NEWPW;
                    timer_load = 1'b1;
                    timer_val  = T_ENTRY_TO;
`endif
                end
            end
            ST_LOCKOUT: begin
                if (timer_done) begin
                    fail_d  = '0;
                    state_d = ST_IDLE;
                end
            end
`ifdef LOCK_PW_CHANGE_EN
            ST_NEWPW: begin
                if (timer_done) begin
                    buf_d   = '0;
                    cnt_d   = 4'd0;
                    state_d = ST_IDLE;
                end else if (key_ok) begin
                    timer_load = 1'b1;
                    timer_val  = T_ENTRY_TO;
                    if (key_dig && (cnt_q < PW_LEN_C)) begin
                        buf_d = (buf_q << 4) | BW'(bus.key_value);
                        cnt_d = cnt_q + 1'b1;
                    end else if (key_star || key_hash) begin
                        if (key_hash && (cnt_q == PW_LEN_C)) begin
                            pw_d     = buf_q;
                            pw_chg_d = 1'b1;
                        end
                        buf_d   = '0;
                        cnt_d   = 4'd0;
                        state_d = ST_IDLE;
                    end
                end
            end
`endif
            default: begin
                buf_d   = '0;
                cnt_d   = 4'd0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, entry buffer, fail counter and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            buf_q      <= '0;
            cnt_q      <= 4'd0;
            fail_q     <= '0;
            unlocked_q <= 1'b0;
            alarm_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            cnt_q      <= cnt_d;
            fail_q     <= fail_d;
            unlocked_q <= (state_d == ST_OPEN);
            alarm_q    <= (state_d == ST_LOCKOUT);
            err_q      <= err_d;
        end
    end

`ifdef LOCK_PW_CHANGE_EN
    // Stored passcode; reset always restores the factory value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pw_q     <= DEFAULT_PW[BW-1:0];
            pw_chg_q <= 1'b0;
        end else begin
            pw_q     <= pw_d;
            pw_chg_q <= pw_chg_d;
        end
    end
    assign bus.pw_chg = pw_chg_q;
`else
    assign bus.pw_chg = 1'b0;
`endif

    assign bus.unlocked  = unlocked_q;
    assign bus.alarm     = alarm_q;
    assign bus.err       = err_q;
    assign bus.digit_cnt = cnt_q;
    assign bus.state     = state_q;

endmodule

// File: tb/tb_lock_ctrl.sv
// Self-checking bench for lock_ctrl with short timers (UNLOCK=100,
// LOCKOUT=200, ENTRY_TO=500). Keys are driven on the falling edge and
// outputs are sampled on the falling edge.
module tb_lock_ctrl;
    import lock_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    lock_ctrl_if ifc ();

    lock_ctrl #(
        .PW_LEN          (4),
        .DEFAULT_PW      (32'h0000_1234),
        .MAX_FAIL        (3),
        .UNLOCK_CYCLES   (100),
        .LOCKOUT_CYCLES  (200),
        .ENTRY_TO_CYCLES (500)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    typedef struct {
        logic [3:0] key;
        logic [2:0] st;
        logic [3:0] cnt;
        logic       unl;
    } vec_t;

    vec_t vecs[17];
    int   checks  = 0;
    int   errors  = 0;
    int   alarm_n = 0;
    int   n;

    // Total number of cycles the alarm output has been seen high.
    always @(negedge clk) begin
        if (ifc.alarm) alarm_n++;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic press(input logic [3:0] k);
        @(negedge clk);
        ifc.key_flag  = 1'b1;
        ifc.key_value = k;
        @(negedge clk);
        ifc.key_flag  = 1'b0;
        ifc.key_value = 4'd0;
    endtask

    // Press n digits (most significant nibble first) followed by '#'.
    task automatic try_code(input logic [15:0] code, input int cnt);
        for (int i = cnt - 1; i >= 0; i--) press(code[4*i +: 4]);
        press(KEY_HASH);
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        ifc.key_flag  = 1'b0;
        ifc.key_value = 4'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        // {key, state, digit_cnt, unlocked} after each key is consumed.
        vecs[0]  = '{4'd12, 3'd0, 4'd0, 1'b0};
        vecs[1]  = '{4'd10, 3'd0, 4'd0, 1'b0};
        vecs[2]  = '{4'd11, 3'd0, 4'd0, 1'b0};
        vecs[3]  = '{4'd1,  3'd1, 4'd1, 1'b0};
        vecs[4]  = '{4'd13, 3'd1, 4'd1, 1'b0};
        vecs[5]  = '{4'd2,  3'd1, 4'd2, 1'b0};
        vecs[6]  = '{4'd10, 3'd0, 4'd0, 1'b0};
        vecs[7]  = '{4'd1,  3'd1, 4'd1, 1'b0};
        vecs[8]  = '{4'd2,  3'd1, 4'd2, 1'b0};
        vecs[9]  = '{4'd3,  3'd1, 4'd3, 1'b0};
        vecs[10] = '{4'd4,  3'd1, 4'd4, 1'b0};
        vecs[11] = '{4'd5,  3'd1, 4'd4, 1'b0};
        vecs[12] = '{4'd11, 3'd2, 4'd4, 1'b0};
        vecs[13] = '{4'd7,  3'd3, 4'd0, 1'b1};
        vecs[14] = '{4'd14, 3'd3, 4'd0, 1'b1};
`ifdef LOCK_PW_CHANGE_EN
        vecs[15] = '{4'd11, 3'd5, 4'd0, 1'b0};
`else
        vecs[15] = '{4'd11, 3'd3, 4'd0, 1'b1};
`endif
        vecs[16] = '{4'd10, 3'd0, 4'd0, 1'b0};

        // Reset state.
        do_reset();
        @(negedge clk);
        chk("rst_state", int'(ifc.state), 0);
        chk("rst_digit_cnt", int'(ifc.digit_cnt), 0);
        chk("rst_unlocked", int'(ifc.unlocked), 0);
        chk("rst_alarm", int'(ifc.alarm), 0);
        chk("rst_err", int'(ifc.err), 0);
        chk("rst_pw_chg", int'(ifc.pw_chg), 0);

        // Correct code: one CHECK cycle, then exactly 100 unlocked cycles.
        try_code(16'h1234, 4);
        chk("a_check_state", int'(ifc.state), 2);
        @(negedge clk);
        chk("a_open_state", int'(ifc.state), 3);
        chk("a_open_unlocked", int'(ifc.unlocked), 1);
        n = 1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (ifc.unlocked) n++;
            else break;
        end
        chk("a_unlock_len", n, 100);
        chk("a_back_idle", int'(ifc.state), 0);

        // Table: invalid keys, '*' abort, fifth digit ignored, OPEN behaviour.
        foreach (vecs[i]) begin
            press(vecs[i].key);
            chk($sformatf("vec%0d_state", i), int'(ifc.state), int'(vecs[i].st));
            chk($sformatf("vec%0d_cnt", i), int'(ifc.digit_cnt), int'(vecs[i].cnt));
            chk($sformatf("vec%0d_unlocked", i), int'(ifc.unlocked), int'(vecs[i].unl));
        end

        // Three wrong codes: err each time, third one enters lockout.
        for (int r = 0; r < 3; r++) begin
            try_code(16'h1235, 4);
            chk($sformatf("b%0d_check", r), int'(ifc.state), 2);
            @(negedge clk);
            chk($sformatf("b%0d_err", r), int'(ifc.err), 1);
            chk($sformatf("b%0d_state", r), int'(ifc.state), (r < 2) ? 0 : 4);
        end
        @(negedge clk);
        chk("b_err_one_cycle", int'(ifc.err), 0);
        chk("b_alarm", int'(ifc.alarm), 1);
        try_code(16'h1234, 4);
        chk("b_lock_ignores_keys", int'(ifc.state), 4);
        chk("b_lock_not_unlocked", int'(ifc.unlocked), 0);
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (!ifc.alarm) break;
        end
        chk("b_alarm_len", alarm_n, 200);
        chk("b_after_lock_state", int'(ifc.state), 0);
        try_code(16'h1234, 4);
        chk("b_relock_check", int'(ifc.state), 2);
        @(negedge clk);
        chk("b_unlock_after_lock", int'(ifc.unlocked), 1);
        press(KEY_STAR);
        chk("b_star_close", int'(ifc.state), 0);

        // Entry timeout boundary: still ENTRY after 499 idle cycles, IDLE after 500.
        press(4'd1);
        chk("d_entry", int'(ifc.state), 1);
        repeat (499) @(negedge clk);
        chk("d_before_to", int'(ifc.state), 1);
        @(negedge clk);
        chk("d_after_to", int'(ifc.state), 0);
        chk("d_after_to_cnt", int'(ifc.digit_cnt), 0);

        // A key landing on the expiry edge is dropped.
        press(4'd1);
        repeat (498) @(negedge clk);
        press(4'd2);
        chk("d_collide_state", int'(ifc.state), 0);
        chk("d_collide_cnt", int'(ifc.digit_cnt), 0);

        // Short entry is a mismatch.
        try_code(16'h0123, 3);
        chk("d_short_check", int'(ifc.state), 2);
        @(negedge clk);
        chk("d_short_err", int'(ifc.err), 1);
        chk("d_short_idle", int'(ifc.state), 0);

`ifdef LOCK_PW_CHANGE_EN
        // Passcode change, old code rejected, new code accepted, reset restores.
        try_code(16'h1234, 4);
        @(negedge clk);
        press(KEY_HASH);
        chk("e_newpw", int'(ifc.state), 5);
        press(4'd9); press(4'd8); press(4'd7); press(4'd6);
        chk("e_newpw_cnt", int'(ifc.digit_cnt), 4);
        press(KEY_HASH);
        chk("e_pw_chg", int'(ifc.pw_chg), 1);
        chk("e_pw_chg_idle", int'(ifc.state), 0);
        @(negedge clk);
        chk("e_pw_chg_pulse", int'(ifc.pw_chg), 0);
        try_code(16'h1234, 4);
        @(negedge clk);
        chk("e_old_code_err", int'(ifc.err), 1);
        try_code(16'h9876, 4);
        @(negedge clk);
        chk("e_new_code_open", int'(ifc.unlocked), 1);
        press(KEY_HASH);
        press(4'd5); press(4'd5); press(4'd5); press(4'd5);
        do_reset();
        chk("e_rst_no_pw_chg", int'(ifc.pw_chg), 0);
        chk("e_rst_state", int'(ifc.state), 0);
        try_code(16'h1234, 4);
        @(negedge clk);
        chk("e_default_after_rst", int'(ifc.unlocked), 1);
`else
        // Without the change feature '#' in OPEN does nothing.
        try_code(16'h1234, 4);
        @(negedge clk);
        press(KEY_HASH);
        chk("e_hash_open_state", int'(ifc.state), 3);
        chk("e_hash_no_pw_chg", int'(ifc.pw_chg), 0);
        press(KEY_STAR);
        chk("e_star_close", int'(ifc.state), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lock_ctrl.md
LOCK_CTRL -- requirements
Module: lock_ctrl

Interface
REQ-001 SHALL have parameter PW_LEN, default 4, number of passcode digits (1..8).
REQ-002 SHALL have parameter DEFAULT_PW, default 32'h0000_1234, reset passcode; one BCD nibble per digit, last-entered digit in bits [3:0].
REQ-003 SHALL have parameter MAX_FAIL, default 3, consecutive wrong entries that trigger lockout.
REQ-004 SHALL have parameters UNLOCK_CYCLES (default 50_000_000), LOCKOUT_CYCLES (default 500_000_000) and ENTRY_TO_CYCLES (default 250_000_000), in clk cycles.
REQ-005 SHALL have port clk, input, 1, system clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1; one clock, reset asynchronous and active-high.
REQ-007 SHALL have port key_flag, input, 1, one-cycle pulse marking a debounced keypress.
REQ-008 SHALL have port key_value, input, 4, key code sampled only when key_flag=1: 0-9 digit, 10 '*', 11 '#', 12-15 invalid.
REQ-009 SHALL have outputs unlocked (1), alarm (1), err (1, one-cycle pulse), pw_chg (1, one-cycle pulse), digit_cnt (4, digits currently buffered) and state (3, current FSM encoding).

Function
REQ-010 SHALL implement FSM states IDLE, ENTRY, CHECK, OPEN, LOCKOUT, NEWPW.
REQ-011 SHALL ignore key_flag with key_value 12-15 in every state: no state, buffer or timer change.
REQ-012 IDLE: digit -> buffer = digit, digit_cnt=1, go ENTRY; '*' and '#' ignored.
REQ-013 ENTRY: digit with digit_cnt<PW_LEN shifts buffer left one nibble and increments digit_cnt; digit at digit_cnt==PW_LEN is ignored.
REQ-014 ENTRY: '*' clears buffer and digit_cnt, go IDLE; '#' go CHECK.
REQ-015 ENTRY: no valid key for ENTRY_TO_CYCLES restarts nothing else; clears buffer and digit_cnt, go IDLE, fail_cnt unchanged; each valid key reloads the timer.
REQ-016 CHECK lasts exactly one cycle: match requires digit_cnt==PW_LEN and buffer==stored passcode.
REQ-017 CHECK match: go OPEN, fail_cnt=0; mismatch: err=1 for one cycle, fail_cnt+1; if new fail_cnt==MAX_FAIL go LOCKOUT else IDLE; buffer and digit_cnt cleared in both cases.
REQ-018 OPEN: unlocked=1 from the first OPEN cycle; after UNLOCK_CYCLES cycles go IDLE; '*' go IDLE immediately; digits ignored.
REQ-019 LOCKOUT: alarm=1; all keys ignored; after LOCKOUT_CYCLES cycles go IDLE and fail_cnt=0.
REQ-020 unlocked SHALL be 1 only in OPEN; alarm only in LOCKOUT; both registered outputs.
REQ-021 A key_flag arriving in the same cycle as a timer expiry SHALL be ignored; the expiry transition wins.
REQ-022 Internal timer SHALL be one shared down-counter, width sufficient for the largest parameter, loaded on entry to OPEN, LOCKOUT, ENTRY, NEWPW.

Reset
REQ-023 On rst: state=IDLE, stored passcode=DEFAULT_PW, buffer=0, digit_cnt=0, fail_cnt=0, timer=0, unlocked=0, alarm=0, err=0, pw_chg=0.
REQ-024 rst asserted mid-operation (any state, including NEWPW mid-commit) SHALL restore DEFAULT_PW and abandon the operation with no err/pw_chg pulse.

Configuration
REQ-025 With macro LOCK_PW_CHANGE_EN defined: '#' in OPEN goes NEWPW; NEWPW collects digits as ENTRY, '#' with digit_cnt==PW_LEN writes buffer to stored passcode, pw_chg=1 one cycle, go IDLE; '#' short, '*' or ENTRY_TO_CYCLES timeout go IDLE with passcode unchanged.
REQ-026 Without LOCK_PW_CHANGE_EN: NEWPW state and passcode write logic absent, '#' in OPEN ignored, pw_chg tied 0, passcode constant DEFAULT_PW.

Structure
REQ-027 Package lock_pkg SHALL hold the state enum, key codes KEY_STAR=10, KEY_HASH=11, and digit-range helper constants.
REQ-028 Timer SHALL be sub-module lock_timer (load, load_value, done pulse); all other logic in lock_ctrl.

Verification (PW_LEN=4, DEFAULT_PW=1234, MAX_FAIL=3, UNLOCK=100, LOCKOUT=200, ENTRY_TO=500)
REQ-029 Keys 1,2,3,4,# -> CHECK one cycle, unlocked=1 for exactly 100 cycles, then IDLE.
REQ-030 Keys 1,2,3,5,# three times -> err pulses 1,2, then alarm=1 for 200 cycles; keys 1,2,3,4,# during alarm ignored; after expiry correct code unlocks.
REQ-031 Keys 1,2,* then 1,2,3,4,# -> unlock; keys 1,2,3,4,5,# -> fifth digit ignored, unlock.
REQ-032 Key 1 then 500 idle cycles -> IDLE, digit_cnt=0; keys 1,2,3,# -> err=1 (short entry).
REQ-033 With LOCK_PW_CHANGE_EN: unlock, #, 9,8,7,6,# -> pw_chg=1; 1,2,3,4,# -> err; 9,8,7,6,# -> unlock; assert rst -> 1,2,3,4,# unlocks.
